// File: rtl/range_sched.sv
// Ultrasonic ranging scheduler: periodic trigger, echo-width timing, and mm conversion.
// The echo width in microseconds is scaled by 11239/65536 and clamped to 9999 mm.
module range_sched #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_MS  = 100,
  parameter int TIMEOUT_US = 30000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        echo,
  output logic        trig,
  output logic [13:0] distance,
  output logic        dist_valid,
  output logic        timeout,
  output logic        busy
);

  localparam int US_DIV  = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
  localparam int PER_CYC = (CLK_HZ / 1000) * PERIOD_MS;
  localparam int PER_W   = (PER_CYC > 1) ? $clog2(PER_CYC) : 1;
  localparam int PRE_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;

  localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PER_CYC - 1);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(US_DIV - 1);
  localparam logic [15:0]      TRIG_LAST = 16'(TRIG_US - 1);
  localparam logic [15:0]      TMO_LAST  = 16'(TIMEOUT_US - 1);
  localparam logic [15:0]      TMO_US    = 16'(TIMEOUT_US);
  localparam logic [29:0]      K_MM      = 30'd11239;
  localparam logic [13:0]      DIST_MAX  = 14'd9999;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, CALC, TMO, HOLD} state_t;

  state_t             state_q, state_d;
  logic               echo_m_q, echo_s_q, echo_p_q;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [15:0]        tmr_q, tmr_d;
  logic [PER_W-1:0]   per_q, per_d;
  logic [15:0]        echo_us_q, echo_us_d;
  logic               trig_q, trig_d;
  logic [13:0]        dist_q, dist_d;
  logic               valid_q, valid_d;
  logic               tmo_q, tmo_d;
  logic               busy_q, busy_d;

  logic               us_tick, echo_rise, echo_fall;
  logic [29:0]        prod;
  logic [13:0]        quot;

  assign us_tick   = (pre_q == PRE_LAST);
  assign echo_rise = echo_s_q & ~echo_p_q;
  assign echo_fall = ~echo_s_q & echo_p_q;
  assign prod      = 30'(echo_us_q) * K_MM;
  assign quot      = 14'(prod >> 16);

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    echo_us_d = echo_us_q;
    dist_d    = dist_q;
    valid_d   = 1'b0;
    tmo_d     = tmo_q;
    per_d     = (per_q == PER_LAST) ? per_q : per_q + PER_W'(1);

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = TRIG;
          per_d   = '0;
        end
      end
      TRIG: begin
        if (us_tick) begin
          if (tmr_q == TRIG_LAST) state_d = WAIT_RISE;
          else                    tmr_d   = tmr_q + 16'd1;
        end
      end
      WAIT_RISE: begin
        if (echo_rise) begin
          state_d   = MEASURE;
          echo_us_d = '0;
        end else if (us_tick) begin
          if (tmr_q == TMO_LAST) begin
            state_d = TMO;
            tmo_d   = 1'b1;
          end else begin
            tmr_d = tmr_q + 16'd1;
          end
        end
      end
      MEASURE: begin
        // Result and strobe are registered on the way into CALC so they appear in that cycle.
        if (echo_fall) begin
          state_d = CALC;
          dist_d  = (quot > DIST_MAX) ? DIST_MAX : quot;
          valid_d = 1'b1;
          tmo_d   = 1'b0;
        end else if (echo_us_q == TMO_US) begin
          state_d = TMO;
          tmo_d   = 1'b1;
        end else if (us_tick && echo_s_q) begin
          echo_us_d = echo_us_q + 16'd1;
        end
      end
      CALC:    state_d = HOLD;
      TMO:     state_d = HOLD;
      HOLD: begin
        if (per_q == PER_LAST) begin
          if (enable) begin
            state_d = TRIG;
            per_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Prescaler and state timer restart on every state change.
    if (state_d != state_q) begin
      pre_d = '0;
      tmr_d = '0;
    end else begin
      pre_d = us_tick ? '0 : pre_q + PRE_W'(1);
    end

    trig_d = (state_d == TRIG);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= IDLE;
      echo_m_q  <= 1'b0;
      echo_s_q  <= 1'b0;
      echo_p_q  <= 1'b0;
      pre_q     <= '0;
      tmr_q     <= '0;
      per_q     <= '0;
      echo_us_q <= '0;
      trig_q    <= 1'b0;
      dist_q    <= '0;
      valid_q   <= 1'b0;
      tmo_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      echo_m_q  <= echo;
      echo_s_q  <= echo_m_q;
      echo_p_q  <= echo_s_q;
      pre_q     <= pre_d;
      tmr_q     <= tmr_d;
      per_q     <= per_d;
      echo_us_q <= echo_us_d;
      trig_q    <= trig_d;
      dist_q    <= dist_d;
      valid_q   <= valid_d;
      tmo_q     <= tmo_d;
      busy_q    <= busy_d;
    end
  end

  assign trig       = trig_q;
  assign distance   = dist_q;
  assign dist_valid = valid_q;
  assign timeout    = tmo_q;
  assign busy       = busy_q;

endmodule

// File: doc/range_sched.md
# range_sched

Measurement scheduler for the ultrasonic ranging front end. It fires the sensor trigger pulse on a fixed sample period and times the echo pulse. It converts echo width to a 14-bit millimetre distance and presents each result with a one-cycle valid strobe. It sits between the sensor pins and the speed/display path, which consumes `distance` as its sampled input.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency; `US_DIV = CLK_HZ/1_000_000` cycles per microsecond (integer ≥ 1).
- `TRIG_US`, 10: trigger pulse width in µs.
- `PERIOD_MS`, 100: sample period, measured from trigger start to the next trigger start.
- `TIMEOUT_US`, 30000: maximum wait for echo rise, and maximum echo width, in µs (≤ 65535).
- `clk`, in, 1: system clock; all logic on the rising edge.
- `rst_n`, in, 1: synchronous, active-high reset (asserted = 1).
- `enable`, in, 1: level; start and continue periodic measurement.
- `echo`, in, 1: sensor echo pin, asynchronous.
- `trig`, out, 1: sensor trigger pin.
- `distance`, out, 14: last valid distance in mm, range 0..9999.
- `dist_valid`, out, 1: one-cycle strobe; `distance` is updated in the same cycle.
- `timeout`, out, 1: sticky; the last measurement timed out.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- `echo` passes through a 2-flop synchronizer to give `echo_s`. All edge detection uses `echo_s` and its previous value.
- A µs prescaler counts 0..US_DIV-1 and is cleared on every state entry.
- **IDLE:**
  - `trig`=0.
  - `enable`=1 → TRIG; the period counter is cleared and starts.
- **TRIG:**
  - `trig`=1 for exactly TRIG_US·US_DIV cycles, then → WAIT_RISE.
- **WAIT_RISE:**
  - Rising edge of `echo_s` → MEASURE; `echo_us` is cleared.
  - TIMEOUT_US elapsed without a rise → TMO. An echo already high when this state is entered does not count as a rise.
- **MEASURE:**
  - `echo_us` increments once per µs while `echo_s`=1.
  - Falling edge → CALC.
  - `echo_us` reaches TIMEOUT_US → TMO.
- **CALC (1 cycle):**
  - `distance` ← min(9999, (echo_us · 11239) >> 16), using a 30-bit product.
  - `dist_valid`=1 and `timeout`←0, both in this cycle.
  - Then → HOLD.
- **TMO (1 cycle):**
  - `timeout`←1.
  - `distance` holds its old value and `dist_valid` stays 0.
  - Then → HOLD.
- **HOLD:**
  - Waits until the period counter reaches PERIOD_MS·CLK_HZ/1000 − 1.
  - At that point: `enable`=1 → TRIG, with the period counter cleared. `enable`=0 → IDLE.
  - If the period has already elapsed when HOLD is entered, the exit is taken on the next cycle.
- Deasserting `enable` mid-measurement does not abort. The current measurement completes, and the block then goes to IDLE at the period end.
- The period counter width is $clog2 of the period in cycles. It saturates at its terminal value rather than wrapping.

## Timing
- Reset values: `trig`=0, `distance`=0, `dist_valid`=0, `timeout`=0, `busy`=0, state IDLE.
- Reset asserted mid-operation returns everything to the reset values on that same edge, so `trig` drops immediately.
- IDLE→TRIG: `trig` rises on the edge after `enable` is sampled high.
- Echo path: 2 cycles of synchronizer latency plus 1 cycle of edge detect.
- `dist_valid` is asserted 1 cycle after the registered falling edge (the CALC cycle). `dist_valid` is never high on two consecutive cycles.
- Trigger-start spacing is exactly PERIOD_MS·CLK_HZ/1000 cycles whenever the measurement finishes inside the period.

## Test plan
All scenarios use CLK_HZ=1_000_000 (US_DIV=1), TRIG_US=10, PERIOD_MS=100, TIMEOUT_US=30000.

- **Reset and first trigger:** hold `rst_n`=1 for 5 cycles, then release with `enable`=1 → all outputs are 0 during reset; `trig` is high for exactly 10 cycles; `busy`=1.
- **Nominal echo:** drive an `echo` pulse 1000 µs wide, 200 µs after trigger end → `dist_valid` pulses once; `distance`=171; `timeout`=0. The next `trig` rises exactly 100000 cycles after the first.
- **Far echo:** drive an echo width of 5831 µs → `distance`=999. Then drive an echo width of 0 µs (1-cycle glitch filtered by the synchronizer timing) → `distance` is 0 or 1, and `dist_valid` is still a single pulse.
- **No echo:** keep `echo`=0 → after 30000 µs, `timeout`=1, no `dist_valid`, and `distance` holds 999. A following good 1000 µs echo clears `timeout` and gives `distance`=171.
- **Stuck-high echo, then disable:**
  - Hold `echo`=1 through the whole trigger → WAIT_RISE times out and `timeout`=1.
  - Drop `enable` during the next MEASURE → that measurement completes, then `busy`=0, `trig` stays 0, and the state is IDLE at the period end.
- **Reset mid-trigger:** assert `rst_n` while `trig`=1 → `trig`=0 on that edge; `distance`=0; no `dist_valid`.
